// File: rtl/muldiv_if.sv
// Operand/result bundle between the execute stage and the iterative multiply/divide unit.
// A request is taken at a rising edge while start=1, flush=0 and busy=0; results are valid for the single done cycle.
interface muldiv_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       Op;
  logic             sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Out;
  logic             Ofl;
  logic             divz;
  logic [1:0]       state;

  modport master (
    output start, Op, sign, A, B, flush,
    input  busy, done, Out, Ofl, divz, state
  );

  modport slave (
    input  start, Op, sign, A, B, flush,
    output busy, done, Out, Ofl, divz, state
  );
endinterface

// File: rtl/muldiv.sv
// Iterative 16-bit multiply/divide: 16 shift-add or restoring shift-subtract steps,
// then one cycle of sign fix-up before a single-cycle done pulse.
module muldiv #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_r;
  logic                 sign_r;
  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [3:0]           cnt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     rem_q, dvd_q;
  logic [WIDTH-1:0]     out_q;
  logic                 ofl_q, divz_q;

  logic                 accept, divz_in, a_neg_in, b_neg_in;
  logic [WIDTH-1:0]     a_mag_in, b_mag_in;
  logic [WIDTH:0]       trial;
  logic                 ge;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s, res;
  logic                 res_ofl, mul_ofl, div_ofl;

  assign accept   = bus.start && !bus.flush && (state_q == IDLE || state_q == DONE);
  assign divz_in  = (bus.Op == 2'b01 || bus.Op == 2'b10) && (bus.B == '0);
  assign a_neg_in = bus.sign && bus.A[WIDTH-1];
  assign b_neg_in = bus.sign && bus.B[WIDTH-1];
  assign a_mag_in = a_neg_in ? -bus.A : bus.A;
  assign b_mag_in = b_neg_in ? -bus.B : bus.B;

  // Restoring step: the dividend shifts out its MSB while quotient bits shift in at the bottom.
  assign trial  = {rem_q, dvd_q[WIDTH-1]};
  assign ge     = trial >= {1'b0, b_mag};
  assign diff   = trial[WIDTH-1:0] - b_mag;
  assign addend = {{WIDTH{1'b0}}, a_mag} << cnt;

  assign prod_s  = (neg_a ^ neg_b) ? -prod : prod;
  assign quo_s   = (neg_a ^ neg_b) ? -dvd_q : dvd_q;
  assign rem_s   = neg_a ? -rem_q : rem_q;
  assign mul_ofl = sign_r ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                          : (prod[2*WIDTH-1:WIDTH] != '0);
  // Only -32768 / -1 yields a quotient magnitude that cannot be represented.
  assign div_ofl = sign_r && neg_a && neg_b && (a_mag == {1'b1, {(WIDTH-1){1'b0}}})
                   && (b_mag == {{(WIDTH-1){1'b0}}, 1'b1});

  always_comb begin
    res     = prod_s[WIDTH-1:0];
    res_ofl = mul_ofl;
    case (op_r)
      2'b01: begin res = quo_s; res_ofl = div_ofl; end
      2'b10: begin res = rem_s; res_ofl = 1'b0;    end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? (divz_in ? DONE : RUN) : IDLE;
      RUN:        if (bus.flush) state_d = IDLE;
                  else if (cnt == 4'd15) state_d = FIX;
      FIX:        state_d = bus.flush ? IDLE : DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r <= '0; sign_r <= 1'b0; neg_a <= 1'b0; neg_b <= 1'b0;
      a_mag <= '0; b_mag <= '0; cnt <= '0; prod <= '0;
      rem_q <= '0; dvd_q <= '0; out_q <= '0; ofl_q <= 1'b0; divz_q <= 1'b0;
    end else if (accept) begin
      op_r   <= bus.Op;
      sign_r <= bus.sign;
      neg_a  <= a_neg_in;
      neg_b  <= b_neg_in;
      a_mag  <= a_mag_in;
      b_mag  <= b_mag_in;
      cnt    <= '0;
      prod   <= '0;
      rem_q  <= '0;
      dvd_q  <= a_mag_in;
      ofl_q  <= 1'b0;
      divz_q <= divz_in;
      if (divz_in) out_q <= (bus.Op == 2'b01) ? {WIDTH{1'b1}} : bus.A;
    end else if (state_q == RUN && !bus.flush) begin
      cnt   <= cnt + 4'd1;
      if (b_mag[cnt]) prod <= prod + addend;
      rem_q <= ge ? diff : trial[WIDTH-1:0];
      dvd_q <= {dvd_q[WIDTH-2:0], ge};
    end else if (state_q == FIX && !bus.flush) begin
      out_q <= res;
      ofl_q <= res_ofl;
    end
  end

  assign bus.busy  = (state_q == RUN) || (state_q == FIX);
  assign bus.done  = (state_q == DONE);
  assign bus.Out   = out_q;
  assign bus.Ofl   = ofl_q;
  assign bus.divz  = divz_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: timing, signed/unsigned MUL/DIV/REM, divide-by-zero,
// flush, ignored start, back-to-back and asynchronous reset.
module tb_muldiv;

  localparam logic [1:0] OP_MUL = 2'd0, OP_DIV = 2'd1, OP_REM = 2'd2, OP_RSV = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1;

  typedef struct packed {
    logic [1:0]  op;
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        ofl;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(16)) bus ();
  muldiv #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; drives start for one edge and returns at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] op, input logic s, input logic [15:0] a,
                        input logic [15:0] b, output int done_cyc, output int busy_cnt);
    bus.Op = op; bus.sign = s; bus.A = a; bus.B = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_cyc = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done) begin done_cyc = c; break; end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.Op = OP_MUL; bus.sign = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", bus.state, ST_IDLE); end
    checks++; if ({bus.busy, bus.done, bus.Ofl, bus.divz} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {bus.busy, bus.done, bus.Ofl, bus.divz}); end
    checks++; if (bus.Out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h exp 0000", bus.Out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_timing();
    int dc, bc;
    run_op(OP_MUL, 1'b0, 16'd300, 16'd200, dc, bc);
    checks++; if (dc !== 18) begin errors++; $display("FAIL mul_done_cycle: got %0d exp 18", dc); end
    checks++; if (bc !== 17) begin errors++; $display("FAIL mul_busy_cycles: got %0d exp 17", bc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_in_done: got %b exp 0", bus.busy); end
    checks++; if (bus.Out !== 16'hEA60 || bus.Ofl !== 1'b0) begin errors++; $display("FAIL mul_u_result: got %h/%b exp ea60/0", bus.Out, bus.Ofl); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.state !== ST_IDLE || bus.Out !== 16'hEA60) begin errors++; $display("FAIL mul_after_done: done=%b state=%0d out=%h exp 0/0/ea60", bus.done, bus.state, bus.Out); end
  endtask

  task automatic test_vectors();
    vec_t v[16];
    int dc, bc;
    v = '{
      '{OP_MUL, 1'b1, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0},
      '{OP_MUL, 1'b1, 16'h0100, 16'h0100, 16'h0000, 1'b1},
      '{OP_MUL, 1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b1},
      '{OP_MUL, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b1},
      '{OP_RSV, 1'b0, 16'h0005, 16'h0006, 16'h001E, 1'b0},
      '{OP_MUL, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0},
      '{OP_MUL, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1},
      '{OP_DIV, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0},
      '{OP_REM, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0},
      '{OP_DIV, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b1},
      '{OP_REM, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0},
      '{OP_DIV, 1'b0, 16'd100,  16'd7,    16'h000E, 1'b0},
      '{OP_REM, 1'b0, 16'd100,  16'd7,    16'h0002, 1'b0},
      '{OP_DIV, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 1'b0},
      '{OP_REM, 1'b1, 16'h0007, 16'hFFFE, 16'h0001, 1'b0},
      '{OP_DIV, 1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 1'b0}
    };
    for (int i = 0; i < 16; i++) begin
      run_op(v[i].op, v[i].s, v[i].a, v[i].b, dc, bc);
      checks++; if (dc !== 18) begin errors++; $display("FAIL vec%0d_done_cycle: got %0d exp 18", i, dc); end
      checks++; if (bus.Out !== v[i].out || bus.Ofl !== v[i].ofl || bus.divz !== 1'b0) begin
        errors++; $display("FAIL vec%0d_result: got out=%h ofl=%b divz=%b exp out=%h ofl=%b divz=0", i, bus.Out, bus.Ofl, bus.divz, v[i].out, v[i].ofl);
      end
    end
  endtask

  task automatic test_divz();
    int dc, bc;
    run_op(OP_REM, 1'b0, 16'h1234, 16'h0000, dc, bc);
    checks++; if (dc !== 1 || bc !== 0) begin errors++; $display("FAIL divz_rem_timing: got done=%0d busy=%0d exp 1/0", dc, bc); end
    checks++; if (bus.Out !== 16'h1234 || bus.divz !== 1'b1 || bus.Ofl !== 1'b0) begin errors++; $display("FAIL divz_rem_result: got %h/%b/%b exp 1234/1/0", bus.Out, bus.divz, bus.Ofl); end
    run_op(OP_DIV, 1'b1, 16'h1234, 16'h0000, dc, bc);
    checks++; if (dc !== 1 || bc !== 0) begin errors++; $display("FAIL divz_div_timing: got done=%0d busy=%0d exp 1/0", dc, bc); end
    checks++; if (bus.Out !== 16'hFFFF || bus.divz !== 1'b1) begin errors++; $display("FAIL divz_div_result: got %h/%b exp ffff/1", bus.Out, bus.divz); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.Out !== 16'hFFFF || bus.divz !== 1'b1) begin errors++; $display("FAIL divz_hold: got done=%b out=%h divz=%b exp 0/ffff/1", bus.done, bus.Out, bus.divz); end
  endtask

  task automatic test_flush_ignore();
    int dc, bc, seen;
    run_op(OP_MUL, 1'b0, 16'd2, 16'd3, dc, bc);
    checks++; if (bus.Out !== 16'h0006) begin errors++; $display("FAIL flush_pre_result: got %h exp 0006", bus.Out); end
    @(negedge clk);
    bus.Op = OP_MUL; bus.sign = 1'b0; bus.A = 16'd3; bus.B = 16'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.state !== ST_IDLE || bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got state=%0d busy=%b exp 0/0", bus.state, bus.busy); end
    seen = 0;
    repeat (20) begin if (bus.done) seen++; @(negedge clk); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done cycles exp 0", seen); end
    checks++; if (bus.Out !== 16'h0006) begin errors++; $display("FAIL flush_out_held: got %h exp 0006", bus.Out); end
    bus.Op = OP_MUL; bus.sign = 1'b0; bus.A = 16'd9; bus.B = 16'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 8) begin bus.Op = OP_DIV; bus.A = 16'd2; bus.B = 16'd2; bus.start = 1'b1; end
      if (c == 9) bus.start = 1'b0;
      if (bus.done) begin dc = c; break; end
      @(negedge clk);
    end
    checks++; if (dc !== 18) begin errors++; $display("FAIL ignore_done_cycle: got %0d exp 18", dc); end
    checks++; if (bus.Out !== 16'h0051) begin errors++; $display("FAIL ignore_result: got %h exp 0051", bus.Out); end
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    run_op(OP_MUL, 1'b0, 16'd10, 16'd10, dc, bc);
    checks++; if (dc !== 18 || bus.Out !== 16'h0064) begin errors++; $display("FAIL b2b_first: got done=%0d out=%h exp 18/0064", dc, bus.Out); end
    run_op(OP_DIV, 1'b0, 16'd100, 16'd10, dc, bc);
    checks++; if (dc !== 18 || bc !== 17) begin errors++; $display("FAIL b2b_second_timing: got done=%0d busy=%0d exp 18/17", dc, bc); end
    checks++; if (bus.Out !== 16'h000A) begin errors++; $display("FAIL b2b_second_result: got %h exp 000a", bus.Out); end
  endtask

  task automatic test_reset_mid_run();
    bus.Op = OP_MUL; bus.sign = 1'b0; bus.A = 16'd5; bus.B = 16'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.state !== ST_RUN || bus.Out !== 16'h000A) begin errors++; $display("FAIL rst_pre: got state=%0d out=%h exp 1/000a", bus.state, bus.Out); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.state !== ST_IDLE || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_async_state: got state=%0d busy=%b done=%b exp 0/0/0", bus.state, bus.busy, bus.done); end
    checks++; if (bus.Out !== 16'h0000 || bus.Ofl !== 1'b0 || bus.divz !== 1'b0) begin errors++; $display("FAIL rst_async_out: got %h/%b/%b exp 0000/0/0", bus.Out, bus.Ofl, bus.divz); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.state !== ST_IDLE || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_release: got state=%0d busy=%b exp 0/0", bus.state, bus.busy); end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_vectors();
    test_divz();
    test_flush_ignore();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
